// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N-way select mux with valid/ready on both sides.
//
// Picks one WIDTH-bit way out of WAYS packed ways for each accepted request
// and holds it in an output register until downstream takes it. A select that
// does not name an existing way returns zero data with out_err set; such a
// transfer still completes through the normal handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    packed way payloads, way k at [k*WIDTH +: WIDTH]
//   in_sel     way index of the current request
//   in_valid   request valid
//   in_ready   block can accept a request this cycle
//   out_data   selected payload
//   out_sel    in_sel captured with out_data
//   out_err    captured in_sel was >= WAYS
//   out_valid  output register holds a result
//   out_ready  downstream accepts the result
//   xfer_count completed output transfers, wraps silently
//
// Build option MUX_SEL_PIPE_SKID_EN: adds a one-entry skid register behind the
// output register so in_ready comes from a flop instead of from out_ready.
module mux_sel_pipe #(
    parameter int WIDTH = 3,
    parameter int WAYS  = 8,
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WAYS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      xfer_count
);

    // Returns {err, data}. Default is the error result; only a select that
    // matches an existing way clears it, so no out-of-range part-select is
    // ever formed when WAYS is not a power of two.
    function automatic logic [WIDTH:0] way_pick(
        input logic [WAYS*WIDTH-1:0] data,
        input logic [SEL_W-1:0]      sel
    );
        logic [WIDTH:0] res;
        res = {1'b1, {WIDTH{1'b0}}};
        for (int k = 0; k < WAYS; k++) begin
            if (sel == SEL_W'(k)) begin
                res = {1'b0, data[k*WIDTH +: WIDTH]};
            end
        end
        return res;
    endfunction

    logic [WIDTH:0]     pick;
    logic [WIDTH-1:0]   new_data;
    logic               new_err;
    logic               accept;
    logic               ret;

    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_sel_q,  out_sel_d;
    logic               out_err_q,  out_err_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   xfer_q, xfer_d;

    assign pick     = way_pick(in_data, in_sel);
    assign new_data = pick[WIDTH-1:0];
    assign new_err  = pick[WIDTH];
    assign accept   = in_valid && in_ready;
    assign ret      = out_valid_q && out_ready;

    assign xfer_d   = ret ? xfer_q + CNT_W'(1) : xfer_q;

`ifdef MUX_SEL_PIPE_SKID_EN
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [SEL_W-1:0]   skid_sel_q,  skid_sel_d;
    logic               skid_err_q,  skid_err_d;
    logic               skid_valid_q, skid_valid_d;
    logic               out_free;

    // Ready depends only on skid occupancy, breaking the out_ready->in_ready path.
    assign in_ready = !skid_valid_q;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_err_d    = out_err_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        skid_err_d   = skid_err_q;
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            // Older skid entry always goes first to keep FIFO order; accept
            // cannot coincide with a full skid.
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_sel_d    = skid_sel_q;
                out_err_d    = skid_err_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_data_d   = new_data;
                out_sel_d    = in_sel;
                out_err_d    = new_err;
                out_valid_d  = 1'b1;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            skid_data_d  = new_data;
            skid_sel_d   = in_sel;
            skid_err_d   = new_err;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
        end
        skid_data_q <= skid_data_d;
        skid_sel_q  <= skid_sel_d;
        skid_err_q  <= skid_err_d;
    end
`else
    // A result leaving this edge frees the register for a new one.
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = new_data;
            out_sel_d   = in_sel;
            out_err_d   = new_err;
            out_valid_d = 1'b1;
        end else if (ret) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            xfer_q      <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            xfer_q      <= xfer_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_sel    = out_sel_q;
    assign out_err    = out_err_q;
    assign out_valid  = out_valid_q;
    assign xfer_count = xfer_q;

endmodule
